// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate generator with valid/ready handshake, 2-entry skid buffer,
// flush and a saturating count of illegal-format entries.
module imm_ext_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_ext_stage: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic             ill;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  imm;
    } entry_t;

    entry_t            main_q, main_d, skid_q, skid_d, new_e;
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   ext_imm;
    logic              accept, xfer, is_ill;
    logic              unused_instr;

    assign unused_instr = ^instr[6:0];

    always_comb begin
        ext_imm = '0;
        case (immsrc)
            3'b000: ext_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            3'b001: ext_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b010: ext_imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
            3'b011: ext_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: ext_imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            3'b101: ext_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            3'b110: ext_imm = XLEN'(instr[19:15]);
            default: ext_imm = '0;
        endcase
    end

    assign is_ill = (immsrc == 3'b111);
    assign new_e  = '{ill: is_ill, tag: in_tag, imm: ext_imm};
    // Input offered during flush is dropped, so it neither enters the buffer nor counts.
    assign accept = in_valid & in_ready & ~flush;
    assign xfer   = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                main_d       = accept ? new_e : main_q;
            end
        end else if (accept) begin
            skid_d       = new_e;
            skid_valid_d = 1'b1;
        end
    end

    assign cnt_d = (accept && is_ill && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = ~skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_tag     = main_q.tag;
    assign out_illegal = main_q.ill;
    assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed checks of three configurations (XLEN=32, XLEN=64, CNT_W=2)
// driven by a shared input stream.
module tb_imm_ext_stage;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr, in_tag;
    logic [2:0]  immsrc;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64, rdyc, vldc, illc;
    logic [31:0] imm32, tag32, immc, tagc, tag64;
    logic [63:0] imm64;
    logic [7:0]  cnt32, cnt64;
    logic [1:0]  cntc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_stage #(.XLEN(32), .TAG_W(32), .CNT_W(8)) d32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32));

    imm_ext_stage #(.XLEN(64), .TAG_W(32), .CNT_W(8)) d64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64));

    imm_ext_stage #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dc (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdyc),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(vldc), .out_ready(out_ready),
        .out_imm(immc), .out_tag(tagc), .out_illegal(illc), .illegal_cnt(cntc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [31:0] t);
        in_valid = v;
        instr    = ins;
        immsrc   = src;
        in_tag   = t;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        tick; tick;
        chk("rst_valid", vld32, 0);
        chk("rst_ready", rdy32, 1);
        chk("rst_imm", imm32, 0);
        chk("rst_tag", tag32, 0);
        chk("rst_ill", ill32, 0);
        chk("rst_cnt", cnt32, 0);
        reset = 1'b0;

        drive(1'b1, 32'hFFF00093, 3'b000, 32'h100); tick;
        chk("i_valid", vld32, 1);
        chk("i_imm32", imm32, 64'hFFFFFFFF);
        chk("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        chk("i_tag", tag32, 32'h100);
        drive(1'b1, 32'hFE000EE3, 3'b001, 32'h101); tick;
        chk("b_imm", imm32, 64'hFFFFFFFC);
        chk("b_tag", tag32, 32'h101);
        drive(1'b1, 32'h0080006F, 3'b011, 32'h102); tick;
        chk("j_imm", imm32, 64'h8);
        drive(1'b1, 32'h800000B7, 3'b100, 32'h103); tick;
        chk("u_imm32", imm32, 64'h80000000);
        chk("u_imm64", imm64, 64'hFFFFFFFF80000000);
        drive(1'b1, 32'h02A01093, 3'b101, 32'h104); tick;
        chk("sh_imm64", imm64, 64'h2A);
        chk("sh_imm32", imm32, 64'h0A);
        drive(1'b1, 32'h000F8073, 3'b110, 32'h105); tick;
        chk("zimm_imm", imm32, 64'h1F);
        drive(1'b1, 32'hFE112E23, 3'b010, 32'h106); tick;
        chk("s_imm", imm32, 64'hFFFFFFFC);
        chk("s_ill", ill32, 0);
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 32'h107); tick;
        chk("ill_imm", imm32, 0);
        chk("ill_flag", ill32, 1);
        chk("ill_cnt", cnt32, 1);
        drive(1'b0, 32'h0, 3'b000, 32'h0); tick;
        chk("drain_valid", vld32, 0);

        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000, 32'h1); tick;
        chk("bp1_tag", tag32, 1);
        chk("bp1_ready", rdy32, 1);
        drive(1'b1, 32'h00100093, 3'b000, 32'h2); tick;
        chk("bp2_ready", rdy32, 0);
        chk("bp2_tag", tag32, 1);
        drive(1'b1, 32'h00100093, 3'b000, 32'h3); tick;
        chk("bp3_ready", rdy32, 0);
        chk("bp3_tag", tag32, 1);
        chk("bp3_imm", imm32, 1);
        out_ready = 1'b1; tick;
        chk("bp_out2", tag32, 2);
        chk("bp_out2_ready", rdy32, 1);
        tick;
        chk("bp_out3", tag32, 3);
        chk("bp_out3_valid", vld32, 1);
        drive(1'b0, 32'h0, 3'b000, 32'h0); tick;
        chk("bp_empty", vld32, 0);

        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000, 32'h4); tick;
        drive(1'b1, 32'h00100093, 3'b000, 32'h5); tick;
        chk("fl_full", rdy32, 0);
        flush = 1'b1;
        drive(1'b1, 32'h0, 3'b111, 32'h6); tick;
        chk("fl_valid", vld32, 0);
        chk("fl_ready", rdy32, 1);
        chk("fl_cnt", cnt32, 1);
        drive(1'b1, 32'h0, 3'b111, 32'h8); tick;
        chk("fl_drop_valid", vld32, 0);
        chk("fl_drop_cnt", cnt32, 1);
        flush = 1'b0; out_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h12345678, 3'b111, 32'h20 + i); tick;
        end
        chk("sat_cnt", cntc, 3);
        chk("cnt32_6", cnt32, 6);
        chk("sat_imm", immc, 0);
        chk("sat_ill", illc, 1);
        chk("sat_tag", tagc, 32'h24);
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        reset = 1'b1; tick;
        chk("rst2_cnt", cntc, 0);
        chk("rst2_valid", vldc, 0);
        chk("rst2_ill", illc, 0);
        chk("rst2_tag", tagc, 0);
        chk("rst2_ready", rdyc, 1);
        chk("rst2_imm64", imm64, 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
